// File: rtl/instr_fetch.sv
// instr_fetch: program memory + program counter feeding the decoder handshake.
// Presents one 32-bit word at a time on instr/instr_valid. It advances on
// instr_valid && next_instr and stops at a zero word or after address DEPTH-1.
// Optional feature macro: INSTR_FETCH_CNT_EN adds the 32-bit fetch_cnt output,
// which counts transfers since the last accepted start.
module instr_fetch #(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              next_instr,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
`ifdef INSTR_FETCH_CNT_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LP_LAST_PC  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rd_data;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_instr_load;
  logic              w_stopped;
  logic              w_start_ok;
  logic              w_wr_en;
  logic              w_xfer;

  // Loads and starts are only accepted while the block is not executing.
  assign w_stopped  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_ok = start && w_stopped;
  assign w_wr_en    = load_en && w_stopped;
  assign w_xfer     = (r_state == S_PRESENT) && next_instr;

  // Next-state, next-PC and instruction-capture decode.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_load = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_state_next = S_FETCH;
          w_pc_next    = LP_RESET_PC;
        end
      end
      S_FETCH: begin
        // A zero word marks the end of the program and is never presented.
        if (r_rd_data == 32'h0000_0000) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_PRESENT;
          w_instr_load = 1'b1;
        end
      end
      S_PRESENT: begin
        if (next_instr) begin
          if (r_pc == LP_LAST_PC) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_FETCH;
            w_pc_next    = r_pc + ADDR_W'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Program memory with a registered read at the next PC. A write to the
  // address being read forwards the new data (write-first), so a load in the
  // same cycle as start is seen by the following FETCH.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[load_addr] <= load_data;
    end
    if (w_wr_en && (load_addr == w_pc_next)) begin
      r_rd_data <= load_data;
    end else begin
      r_rd_data <= r_mem[w_pc_next];
    end
  end

  // Control state, program counter and presented instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= LP_RESET_PC;
      r_instr <= 32'h0000_0000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_instr_load) begin
        r_instr <= r_rd_data;
      end
    end
  end

`ifdef INSTR_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  // Transfer counter, cleared by every accepted start and wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= 32'h0000_0000;
    end else if (w_start_ok) begin
      r_fetch_cnt <= 32'h0000_0000;
    end else if (w_xfer) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`endif

  assign instr       = r_instr;
  assign instr_valid = (r_state == S_PRESENT);
  assign pc          = r_pc;
  assign busy        = (r_state == S_FETCH) || (r_state == S_PRESENT);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: expected {pc, instr} pairs are queued when a run is
// set up and popped by a monitor on every transfer (instr_valid && next_instr).
module tb_instr_fetch;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              next_instr;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
`ifdef INSTR_FETCH_CNT_EN
  logic [31:0]       fetch_cnt;
`endif

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_mis  = 0;
  int   n_xfer = 0;

  instr_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .next_instr  (next_instr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
`ifdef INSTR_FETCH_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one line per transfer.
  always @(negedge clk) begin
    if (!reset && instr_valid && next_instr) begin
      n_xfer++;
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("xfer pc=%0d instr=%08h (exp pc=%0d instr=%08h)", pc, instr, e.pc, e.instr);
        check("xfer", {pc, instr}, {e.pc, e.instr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    exp_t e;
    e.pc    = ADDR_W'(a);
    e.instr = d;
    sb.push_back(e);
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!instr_valid && k < budget) begin
      tick();
      k++;
    end
    check("valid_reached", 64'(instr_valid), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    int x0;
    reset      = 1'b1;
    start      = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    next_instr = 1'b0;

    // Reset values
    #2;
    check("rst_instr", 64'(instr), 64'h0);
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic program with exact latency
    load_word(0, 32'h0050_0093);
    load_word(1, 32'h0020_81B3);
    load_word(2, 32'h0000_0000);
    push_exp(0, 32'h0050_0093);
    push_exp(1, 32'h0020_81B3);
    next_instr = 1'b1;
    x0 = n_xfer;
    do_start();                       // now in N+1 (FETCH)
    check("b_fetch_valid", 64'(instr_valid), 64'h0);
    check("b_fetch_busy", 64'(busy), 64'h1);
    tick();                           // N+2
    check("b_v0", 64'(instr_valid), 64'h1);
    check("b_pc0", 64'(pc), 64'h0);
    tick();                           // N+3 gap
    check("b_gap", 64'(instr_valid), 64'h0);
    tick();                           // N+4
    check("b_v1", 64'(instr_valid), 64'h1);
    check("b_pc1", 64'(pc), 64'h1);
    wait_done(10);
    check("b_xfers", 64'(n_xfer - x0), 64'd2);
    check("b_pc_end", 64'(pc), 64'd2);
    check("b_busy_end", 64'(busy), 64'h0);
`ifdef INSTR_FETCH_CNT_EN
    check("b_cnt", 64'(fetch_cnt), 64'd2);
`endif

    // Backpressure
    next_instr = 1'b0;
    load_word(0, 32'h1111_0001);
    load_word(1, 32'h2222_0002);
    push_exp(0, 32'h1111_0001);
    push_exp(1, 32'h2222_0002);
    do_start();
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 64'(instr_valid), 64'h1);
      check("bp_instr", 64'(instr), 64'h1111_0001);
      tick();
    end
    next_instr = 1'b1;
    wait_done(20);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Last address: 64 nonzero words, no wrap
    for (int i = 0; i < DEPTH; i++) begin
      load_word(i, 32'hA500_0000 + 32'(i));
      push_exp(i, 32'hA500_0000 + 32'(i));
    end
    x0 = n_xfer;
    do_start();
    wait_done(300);
    check("la_xfers", 64'(n_xfer - x0), 64'd64);
    check("la_pc", 64'(pc), 64'd63);
    repeat (3) tick();
    check("la_pc_hold", 64'(pc), 64'd63);
    check("la_done_hold", 64'(done), 64'h1);
`ifdef INSTR_FETCH_CNT_EN
    check("la_cnt", 64'(fetch_cnt), 64'd64);
`endif

    // Load protection: write during PRESENT is dropped
    load_word(2, 32'h0000_0000);
    next_instr = 1'b0;
    push_exp(0, 32'hA500_0000);
    push_exp(1, 32'hA500_0001);
    do_start();
    wait_valid(10);
    load_word(1, 32'hDEAD_BEEF);
    check("lp_still_valid", 64'(instr_valid), 64'h1);
    next_instr = 1'b1;
    wait_done(20);
    check("lp_sb_empty", 64'(sb.size()), 64'd0);

    // Write in DONE is kept; simultaneous load+start is write-first
    load_word(1, 32'hDEAD_BEEF);
    push_exp(0, 32'h1234_5678);
    push_exp(1, 32'hDEAD_BEEF);
    load_en   = 1'b1;
    load_addr = '0;
    load_data = 32'h1234_5678;
    start     = 1'b1;
    tick();
    load_en   = 1'b0;
    start     = 1'b0;
    wait_done(20);
    check("wf_sb_empty", 64'(sb.size()), 64'd0);

    // Start while busy is ignored, then reset mid-run
    next_instr = 1'b0;
    push_exp(0, 32'h1234_5678);
    push_exp(1, 32'hDEAD_BEEF);
    do_start();
    wait_valid(10);
    next_instr = 1'b1;
    tick();
    next_instr = 1'b0;
    wait_valid(10);
    check("rs_pc1", 64'(pc), 64'd1);
    do_start();
    check("rs_ign_valid", 64'(instr_valid), 64'h1);
    check("rs_ign_pc", 64'(pc), 64'd1);
    #3 reset = 1'b1;
    #1;
    check("rr_valid", 64'(instr_valid), 64'h0);
    check("rr_pc", 64'(pc), 64'h0);
    check("rr_instr", 64'(instr), 64'h0);
    check("rr_busy", 64'(busy), 64'h0);
    check("rr_done", 64'(done), 64'h0);
`ifdef INSTR_FETCH_CNT_EN
    check("rr_cnt", 64'(fetch_cnt), 64'd0);
`endif
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    push_exp(0, 32'h1234_5678);
    push_exp(1, 32'hDEAD_BEEF);
    next_instr = 1'b1;
    x0 = n_xfer;
    do_start();
    wait_done(20);
    check("rr_xfers", 64'(n_xfer - x0), 64'd2);
    check("rr_sb_empty", 64'(sb.size()), 64'd0);
`ifdef INSTR_FETCH_CNT_EN
    check("rr_cnt_end", 64'(fetch_cnt), 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
